skid_fifo: RTL

//  Parametrised-depth valid/ready elastic buffer; generalises the 2-entry skid buffer to DEPTH entries.

---
 rtl/skid_fifo.sv | 82 ++++++++
 1 files changed

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer of DEPTH entries: a registered output stage backed by a
// (DEPTH-1)-entry ring. All handshake outputs are registered, so out_ready never reaches in_ready.
module skid_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int RING = DEPTH - 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] ring [RING];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic                  reset_asserted;

    logic          rx, tx, ring_empty, out_free, load, refill, fill_ring;
    logic [CW-1:0] next_count;

    always_comb begin
        rx         = in_valid & in_ready;
        tx         = out_valid & out_ready;
        // The output register holds one entry, so the ring is empty whenever count <= 1.
        ring_empty = (count <= CW'(1));
        out_free   = !out_valid | tx;
        load       = rx & out_free & ring_empty;
        refill     = tx & !ring_empty;
        fill_ring  = rx & !load;
        next_count = count;
        if (rx && !tx)
            next_count = count + CW'(1);
        else if (tx && !rx)
            next_count = count - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count          <= '0;
            out_valid      <= 1'b0;
            in_ready       <= 1'b0;
            out_data       <= '0;
            almost_full    <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            reset_asserted <= 1'b1;
        end else begin
            reset_asserted <= 1'b0;
            count          <= next_count;
            out_valid      <= (next_count != '0);
            in_ready       <= (next_count != DEPTH_C) & !reset_asserted;
            almost_full    <= (next_count >= AF_C);
            if (load)
                out_data <= in_data;
            else if (refill) begin
                out_data <= ring[rd_ptr];
                rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (fill_ring)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        end
    end

    // Ring contents need no reset: the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (fill_ring)
            ring[wr_ptr] <= in_data;
    end
endmodule
